nan_pixel_frame_writer: RTL and testbench
=========================================

# nan_pixel_frame_writer

Downstream consumer of the RX deserializer's parallel pixel stream. It packs consecutive 8-bit pixels of a row into 16-bit words and computes a ping-pong frame-memory word address from the deserializer's ROW_NUM/COL_NUM. Words are buffered in a small FIFO and drained to the frame memory over a valid/ready write port. It also tracks frame completion, frame count and error status for the readout side.

## Interface
Parameters:
- C_ROWS, 250, rows per frame
- C_COLS, 250, columns per row (must be even)
- FIFO_DEPTH, 8, word FIFO depth (power of 2, ≥2)
- ADDR_WIDTH, 16, memory word address width; MSB = bank, low ADDR_WIDTH-1 bits = word index

Ports:
- SCLOCK  in  1  sole clock, all logic rising-edge
- RESET  in  1  synchronous, active-high reset
- FRAME_SYNC_START  in  1  frame enable level from sensor control; rising edge opens a frame
- DEC_RSYNC  in  1  deserializer idle/resync flag
- PAR_DATA  in  8  pixel value
- PAR_DATA_EN  in  1  PAR_DATA/ROW_NUM/COL_NUM valid this cycle
- ROW_NUM  in  8  row of current pixel
- COL_NUM  in  8  column of current pixel
- WR_DATA  out  16  {odd-column pixel, even-column pixel}
- WR_ADDR  out  ADDR_WIDTH  {bank, ROW_NUM*(C_COLS/2) + COL_NUM/2}
- WR_VALID  out  1  write word available
- WR_READY  in  1  memory accepts word
- FRAME_DONE  out  1  one-cycle pulse, frame fully drained
- FRAME_OK  out  1  valid with FRAME_DONE: frame clean and complete
- READ_BANK  out  1  bank of last completed frame
- FRAME_CNT  out  8  completed frames, wraps 255→0
- PIX_OVERFLOW  out  1  sticky: a word was dropped on full FIFO

## Operation
- FSM states IDLE, ACTIVE, DRAIN.
- IDLE: pixels ignored. FRAME_SYNC_START registered each cycle; when current=1 and previous=0, go to ACTIVE, clear per-frame error flag, clear word counter, clear pair-hold.
- ACTIVE, on PAR_DATA_EN:
  - ROW_NUM ≥ C_ROWS or COL_NUM ≥ C_COLS: pixel discarded, frame error set.
  - Even COL_NUM: PAR_DATA held as low byte, hold_col = COL_NUM, hold_valid = 1.
  - Odd COL_NUM: push word {PAR_DATA, low}; if !hold_valid or hold_col ≠ COL_NUM-1, low = 8'h00 and frame error set. hold_valid cleared.
  - Word counter increments per pushed word (15 bits).
- ACTIVE → DRAIN when: the word for (C_ROWS-1, C_COLS-1) is pushed; or DEC_RSYNC rises; or FRAME_SYNC_START falls. In the latter two cases, an incomplete frame sets the frame error.
- DRAIN: pixels ignored; when FIFO empty and no transfer pending: FRAME_DONE=1 for one cycle; FRAME_OK = !frame error && word count == C_ROWS*C_COLS/2; READ_BANK ← bank; bank toggles; FRAME_CNT+1; → IDLE.
- FIFO full on push: word dropped, PIX_OVERFLOW set (cleared only by RESET), frame error set. Push and pop in the same cycle with FIFO full is not overflow.
- Address math: ROW_NUM*(C_COLS/2) computed at full width, summed with COL_NUM>>1; max 31249 for defaults; bank occupies WR_ADDR[ADDR_WIDTH-1].

## Timing
- Reset values: WR_DATA 0, WR_ADDR 0, WR_VALID 0, FRAME_DONE 0, FRAME_OK 0, READ_BANK 0, FRAME_CNT 0, PIX_OVERFLOW 0; FSM IDLE, bank 0, FIFO empty. RESET mid-frame discards all FIFO contents with no FRAME_DONE.
- Push latency: odd pixel sampled at edge E is written into the FIFO at E; with the FIFO previously empty, WR_VALID=1 after edge E+1.
- Handshake: transfer on WR_VALID && WR_READY at an edge; WR_DATA/WR_ADDR stable while WR_VALID && !WR_READY; WR_VALID never drops without a transfer. Sustained throughput is 1 word/cycle.
- FRAME_DONE fires one cycle after the last accepted transfer at the earliest.
- Rising edge of FRAME_SYNC_START during ACTIVE/DRAIN is ignored.

## Test plan
- Full clean frame, WR_READY=1: 250×250 pixels, value = col[7:0] → 31250 words, first {8'h01,8'h00}@0x0000, last {8'hF9,8'hF8}@0x7A11; FRAME_DONE once, FRAME_OK=1, READ_BANK=0, FRAME_CNT=1.
- Second frame → all WR_ADDR[15]=1, READ_BANK=1, FRAME_CNT=2; 256 frames → FRAME_CNT wraps to 0.
- WR_READY=0 during 9 pairs with FIFO_DEPTH=8 → 8 words held, 9th dropped, PIX_OVERFLOW=1, FRAME_OK=0; on WR_READY=1, the 8 words drain in order with stable data/address under stall.
- Missing even pixel (col 4 omitted, col 5=8'hAA) → word {8'hAA,8'h00}@row*125+2, FRAME_OK=0.
- DEC_RSYNC rises after row 10 → DRAIN, FRAME_DONE with FRAME_OK=0; pixels after that ignored until next FRAME_SYNC_START rise.
- RESET asserted with 5 words queued → next cycle WR_VALID=0, FRAME_CNT=0, no FRAME_DONE.

Source files
------------

// File: rtl/nan_pixel_frame_writer_if.sv
// Frame-memory write port: one {address, data} word per valid/ready transfer.
interface nan_pixel_frame_writer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [15:0]           WR_DATA;
    logic [ADDR_WIDTH-1:0] WR_ADDR;
    logic                  WR_VALID;
    logic                  WR_READY;

    modport master (
        output WR_DATA,
        output WR_ADDR,
        output WR_VALID,
        input  WR_READY
    );

    modport slave (
        input  WR_DATA,
        input  WR_ADDR,
        input  WR_VALID,
        output WR_READY
    );
endinterface

// File: rtl/nan_pixel_frame_writer.sv
// Packs pixel pairs of the deserializer stream into 16-bit words, addresses them
// into a ping-pong frame memory and drains them through a small word FIFO.
module nan_pixel_frame_writer #(
    parameter int C_ROWS     = 250,
    parameter int C_COLS     = 250,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                     SCLOCK,
    input  logic                     RESET,
    input  logic                     FRAME_SYNC_START,
    input  logic                     DEC_RSYNC,
    input  logic [7:0]               PAR_DATA,
    input  logic                     PAR_DATA_EN,
    input  logic [7:0]               ROW_NUM,
    input  logic [7:0]               COL_NUM,
    nan_pixel_frame_writer_if.master wr,
    output logic                     FRAME_DONE,
    output logic                     FRAME_OK,
    output logic                     READ_BANK,
    output logic [7:0]               FRAME_CNT,
    output logic                     PIX_OVERFLOW
);
    localparam int HALF_COLS   = C_COLS / 2;
    localparam int TOTAL_WORDS = C_ROWS * C_COLS / 2;
    localparam int PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW          = PW + 1;
    localparam int IW          = ADDR_WIDTH - 1;
    localparam int EW          = ADDR_WIDTH + 16;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic          sync_q, rsync_q;
    logic          err_q;
    logic          bank_q;
    logic          hold_valid_q;
    logic [7:0]    hold_col_q;
    logic [7:0]    hold_data_q;
    logic [14:0]   word_cnt_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, avail;
    logic          valid_q, valid_d;
    logic [15:0]   data_q;
    logic [IW:0]   addr_q;
    logic          done_q, ok_q, read_bank_q, ovf_q;
    logic [7:0]    frame_cnt_q;

    logic          fs_rise, fs_fall, rs_rise;
    logic          start_frame, pix_take, check_end, drain_done;
    logic [31:0]   row_w, col_w;
    logic          row_ok, col_ok, last_pix;
    logic          pix_ok, push_req, pair_hit, pop, fifo_full, push, drop;
    logic          early_end, end_frame, err_set;
    logic [14:0]   word_cnt_inc;
    logic [IW-1:0] word_idx;
    logic [EW-1:0] head;

    assign fs_rise = FRAME_SYNC_START && !sync_q;
    assign fs_fall = !FRAME_SYNC_START && sync_q;
    assign rs_rise = DEC_RSYNC && !rsync_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_frame) state_d = S_ACTIVE;
            S_ACTIVE: if (end_frame)   state_d = S_DRAIN;
            S_DRAIN:  if (drain_done)  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_frame = 1'b0;
        pix_take    = 1'b0;
        check_end   = 1'b0;
        drain_done  = 1'b0;
        unique case (state_q)
            S_IDLE:   start_frame = fs_rise;
            S_ACTIVE: begin
                pix_take  = PAR_DATA_EN;
                check_end = 1'b1;
            end
            S_DRAIN:  drain_done = (count_q == '0) && !valid_q;
            default:  ;
        endcase
    end

    // ------------------------------------------------------ pixel pairing
    assign row_w    = {24'd0, ROW_NUM};
    assign col_w    = {24'd0, COL_NUM};
    assign row_ok   = row_w < C_ROWS;
    assign col_ok   = col_w < C_COLS;
    assign last_pix = (row_w == C_ROWS - 1) && (col_w == C_COLS - 1);
    assign word_idx = IW'(row_w * HALF_COLS + (col_w >> 1));

    assign pix_ok    = pix_take && row_ok && col_ok;
    assign push_req  = pix_ok && COL_NUM[0];
    assign pair_hit  = hold_valid_q && (hold_col_q == COL_NUM - 8'd1);
    assign pop       = valid_q && wr.WR_READY;
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign push      = push_req && (!fifo_full || pop);
    assign drop      = push_req && !push;

    assign word_cnt_inc = word_cnt_q + 15'(push);
    assign early_end    = check_end && (rs_rise || fs_fall);
    assign end_frame    = early_end || (push_req && last_pix);
    assign err_set      = (pix_take && !(row_ok && col_ok))
                        || (push_req && !pair_hit)
                        || drop
                        || (early_end && (word_cnt_inc != 15'(TOTAL_WORDS)));

    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            sync_q       <= 1'b0;
            rsync_q      <= 1'b0;
            err_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_col_q   <= '0;
            hold_data_q  <= '0;
            word_cnt_q   <= '0;
        end else begin
            sync_q  <= FRAME_SYNC_START;
            rsync_q <= DEC_RSYNC;
            if (start_frame) begin
                err_q        <= 1'b0;
                word_cnt_q   <= '0;
                hold_valid_q <= 1'b0;
            end else begin
                if (err_set) err_q <= 1'b1;
                word_cnt_q <= word_cnt_inc;
                if (pix_ok) begin
                    if (COL_NUM[0]) begin
                        hold_valid_q <= 1'b0;
                    end else begin
                        hold_valid_q <= 1'b1;
                        hold_col_q   <= COL_NUM;
                        hold_data_q  <= PAR_DATA;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------- word FIFO
    // The write port shows the FIFO head through a register; words pushed this
    // cycle are never visible yet, so the head read never aliases the write.
    assign count_d  = count_q + CW'(push) - CW'(pop);
    assign avail    = count_q - CW'(pop);
    assign valid_d  = (avail != '0);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign head     = mem_q[rd_ptr_d];

    always_ff @(posedge SCLOCK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bank_q, word_idx, PAR_DATA,
                                pair_hit ? hold_data_q : 8'h00};
        end
    end

    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            if (valid_d) begin
                addr_q <= head[EW-1:16];
                data_q <= head[15:0];
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    // ------------------------------------------------- frame completion
    always_ff @(posedge SCLOCK) begin
        if (RESET) begin
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            read_bank_q <= 1'b0;
            bank_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done_q <= drain_done;
            if (drain_done) begin
                ok_q        <= !err_q && (word_cnt_q == 15'(TOTAL_WORDS));
                read_bank_q <= bank_q;
                bank_q      <= !bank_q;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign wr.WR_DATA   = data_q;
    assign wr.WR_ADDR   = addr_q;
    assign wr.WR_VALID  = valid_q;
    assign FRAME_DONE   = done_q;
    assign FRAME_OK     = ok_q;
    assign READ_BANK    = read_bank_q;
    assign FRAME_CNT    = frame_cnt_q;
    assign PIX_OVERFLOW = ovf_q;
endmodule

// File: tb/tb_nan_pixel_frame_writer.sv
// Bench for nan_pixel_frame_writer: directed frames plus random frames, checked
// against a frame-level model (expected word queue, bank and counters).
module tb_nan_pixel_frame_writer;
    localparam int R     = 6;
    localparam int C     = 10;
    localparam int D     = 8;
    localparam int AW    = 16;
    localparam int HALF  = C / 2;
    localparam int TOTAL = R * C / 2;

    logic       clk = 1'b0;
    logic       rst, fss, rsync, pen, rdy;
    logic [7:0] pd, row, col;
    logic       done, ok, rbank, ovf;
    logic [7:0] fcnt;

    always #5 clk = ~clk;

    nan_pixel_frame_writer_if #(.ADDR_WIDTH(AW)) wif ();
    assign wif.WR_READY = rdy;

    nan_pixel_frame_writer #(
        .C_ROWS(R), .C_COLS(C), .FIFO_DEPTH(D), .ADDR_WIDTH(AW)
    ) dut (
        .SCLOCK(clk), .RESET(rst), .FRAME_SYNC_START(fss), .DEC_RSYNC(rsync),
        .PAR_DATA(pd), .PAR_DATA_EN(pen), .ROW_NUM(row), .COL_NUM(col),
        .wr(wif.master),
        .FRAME_DONE(done), .FRAME_OK(ok), .READ_BANK(rbank),
        .FRAME_CNT(fcnt), .PIX_OVERFLOW(ovf)
    );

    int          checks = 0;
    int          errors = 0;
    // model: 0 idle, 1 collecting a frame, 2 waiting for the memory to drain
    int          m_st;
    bit          m_err, m_bank, m_rbank, m_ovf, m_hv, m_prev_fs, m_prev_rs;
    int          m_words, m_hcol;
    logic [7:0]  m_hdat, m_cnt;
    logic [31:0] q[$];
    bit          rdy_rand, gaps, stalled, last_ok;
    logic [31:0] stall_w;
    int          n_done;
    logic [14:0] watch_addr;
    logic [15:0] watch_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = 0; m_err = 0; m_bank = 0; m_rbank = 0; m_ovf = 0; m_hv = 0;
        m_prev_fs = 0; m_prev_rs = 0; m_words = 0; m_hcol = 0; m_hdat = 8'h00;
        m_cnt = 8'h00; stalled = 0; n_done = 0;
    endtask

    task automatic step(input bit en, input int r, input int c, input logic [7:0] v);
        logic        vld;
        logic [31:0] obs_w, exp_w;
        logic [7:0]  lo;
        bit          xfer, exp_done, exp_ok, last, rs_rise, fs_fall;
        int          old;
        if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
        pen = en; row = 8'(r); col = 8'(c); pd = v;
        vld   = wif.WR_VALID;
        obs_w = {wif.WR_ADDR, wif.WR_DATA};
        if (q.size() == 0) chk("valid_without_word", 32'(vld), 32'd0);
        if (stalled) chk("stall_hold", obs_w, stall_w);
        xfer     = vld && rdy;
        stalled  = vld && !rdy;
        stall_w  = obs_w;
        old      = m_st;
        exp_done = (old == 2) && (q.size() == 0);
        exp_ok   = !m_err && (m_words == TOTAL);
        if (xfer && q.size() > 0) begin
            exp_w = q.pop_front();
            chk("wr_word", obs_w, exp_w);
            if (obs_w[30:16] == watch_addr) watch_data = obs_w[15:0];
        end
        @(posedge clk);
        if (exp_done) begin
            m_rbank = m_bank;
            m_bank  = !m_bank;
            m_cnt   = m_cnt + 8'd1;
            m_st    = 0;
        end
        last    = 0;
        rs_rise = rsync && !m_prev_rs;
        fs_fall = !fss && m_prev_fs;
        if (old == 1) begin
            if (en) begin
                if (r >= R || c >= C) begin
                    m_err = 1;
                end else if (c % 2 == 0) begin
                    m_hv = 1; m_hcol = c; m_hdat = v;
                end else begin
                    lo = (m_hv && m_hcol == c - 1) ? m_hdat : 8'h00;
                    if (!(m_hv && m_hcol == c - 1)) m_err = 1;
                    m_hv = 0;
                    if (q.size() < D) begin
                        q.push_back({m_bank, 15'(r * HALF + c / 2), v, lo});
                        m_words++;
                    end else begin
                        m_ovf = 1; m_err = 1;
                    end
                    if (r == R - 1 && c == C - 1) last = 1;
                end
            end
            if (last || rs_rise || fs_fall) begin
                if ((rs_rise || fs_fall) && m_words != TOTAL) m_err = 1;
                m_st = 2;
            end
        end else if (old == 0 && fss && !m_prev_fs) begin
            m_st = 1; m_err = 0; m_words = 0; m_hv = 0;
        end
        m_prev_fs = fss;
        m_prev_rs = rsync;
        #1;
        chk("frame_done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            chk("frame_ok", 32'(ok), 32'(exp_ok));
            chk("read_bank", 32'(rbank), 32'(m_rbank));
        end
        chk("frame_cnt", 32'(fcnt), 32'(m_cnt));
        chk("pix_overflow", 32'(ovf), 32'(m_ovf));
        if (done) begin
            n_done++;
            last_ok = ok;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00);
    endtask

    task automatic send(input int r, input int c, input logic [7:0] v);
        if (gaps && $urandom_range(0, 2) == 0) idle();
        step(1, r, c, v);
    endtask

    task automatic do_reset();
        rst = 1; pen = 0; fss = 0; rsync = 0; rdy = 1; rdy_rand = 0;
        pd = 8'h00; row = 8'h00; col = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic start_frame();
        fss = 0; idle();
        fss = 1; idle();
    endtask

    // kind 0: pixel = column, kind 1: random; (skip_r, skip_c) is left out
    // and its odd partner carries 8'hAA
    task automatic frame_body(input int kind, input int rows, input int skip_r, input int skip_c);
        logic [7:0] v;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < C; c++) begin
                if (r == skip_r && c == skip_c) continue;
                if (r == skip_r && c == skip_c + 1) v = 8'hAA;
                else if (kind == 0) v = 8'(c);
                else v = 8'($urandom);
                send(r, c, v);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_st != 0 && n < 400) begin
            idle();
            n++;
        end
        chk(tag, 32'(m_st), 32'd0);
    endtask

    initial begin
        int guard, rows, sk_r, sk_c;
        watch_addr = 15'h7FFF;
        watch_data = 16'h0000;
        do_reset();
        chk("rst_valid", 32'(wif.WR_VALID), 32'd0);
        chk("rst_data", 32'(wif.WR_DATA), 32'd0);
        chk("rst_addr", 32'(wif.WR_ADDR), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_rbank", 32'(rbank), 32'd0);
        chk("rst_cnt", 32'(fcnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // clean frame, memory always ready
        gaps = 0; rdy_rand = 0; rdy = 1;
        start_frame();
        frame_body(0, R, -1, -1);
        wait_idle("t1_drain");
        chk("t1_ok", 32'(last_ok), 32'd1);
        chk("t1_cnt", 32'(fcnt), 32'd1);
        chk("t1_rbank", 32'(rbank), 32'd0);

        // second clean frame into bank 1, random gaps and back-pressure
        gaps = 1; rdy_rand = 1;
        start_frame();
        frame_body(1, R, -1, -1);
        wait_idle("t2_drain");
        chk("t2_ok", 32'(last_ok), 32'd1);
        chk("t2_cnt", 32'(fcnt), 32'd2);
        chk("t2_rbank", 32'(rbank), 32'd1);

        // 9 pairs while stalled: 8 held, 9th dropped
        gaps = 0; rdy_rand = 0; rdy = 0;
        start_frame();
        for (int k = 0; k < 18; k++) send(k / C, k % C, 8'($urandom));
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_valid", 32'(wif.WR_VALID), 32'd1);
        rdy = 1; fss = 0; idle();
        wait_idle("t3_drain");
        chk("t3_ok", 32'(last_ok), 32'd0);

        // missing even pixel: row 2 col 4 absent, col 5 = AA
        gaps = 1; rdy_rand = 1;
        watch_addr = 15'(2 * HALF + 2);
        start_frame();
        frame_body(1, R, 2, 4);
        wait_idle("t4_drain");
        chk("t4_ok", 32'(last_ok), 32'd0);
        chk("t4_word", 32'(watch_data), 32'h0000AA00);
        watch_addr = 15'h7FFF;

        // DEC_RSYNC rise ends the frame early; later pixels are ignored
        start_frame();
        frame_body(1, 4, -1, -1);
        rsync = 1; idle();
        for (int c = 0; c < C; c++) send(4, c, 8'($urandom));
        wait_idle("t5_drain");
        rsync = 0;
        for (int c = 0; c < C; c++) send(5, c, 8'($urandom));
        chk("t5_ok", 32'(last_ok), 32'd0);

        // out-of-range pixels spoil an otherwise complete frame
        start_frame();
        send(R, 0, 8'h11);
        send(0, C + 1, 8'h22);
        frame_body(1, R, -1, -1);
        wait_idle("t6_drain");
        chk("t6_ok", 32'(last_ok), 32'd0);

        // random frames until 256 completions, FRAME_CNT wraps
        guard = 0;
        while (n_done < 256 && guard < 300) begin
            guard++;
            start_frame();
            rows = $urandom_range(1, R);
            sk_r = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rows - 1) : -1;
            sk_c = 2 * $urandom_range(0, HALF - 1);
            frame_body(1, rows, sk_r, sk_c);
            if (rows < R) begin
                fss = 0; idle();
            end
            wait_idle("t7_drain");
        end
        chk("t7_frames", 32'(n_done), 32'd256);
        chk("t7_wrap_cnt", 32'(fcnt), 32'd0);

        // reset with 5 words queued
        gaps = 0; rdy_rand = 0; rdy = 0;
        start_frame();
        for (int c = 0; c < C; c++) send(0, c, 8'(c + 1));
        rst = 1;
        @(posedge clk);
        #1;
        chk("t8_valid", 32'(wif.WR_VALID), 32'd0);
        chk("t8_cnt", 32'(fcnt), 32'd0);
        chk("t8_done", 32'(done), 32'd0);
        rst = 0; fss = 0; rdy = 1;
        model_reset();
        repeat (6) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
